// File: rtl/branch_sequencer.sv
// Fetch-PC sequencer: boot hold, sequential/stall/branch/jump next-PC selection, and IF/ID flush window.
// One-cycle PC update latency; stall holds the PC, and the flush cycles ignore all requests.
module branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_pc_i,
  input  logic [31:0] branch_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_addr_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic        flush_o,
  output logic [15:0] redirect_cnt_o
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FLUSH1 = 2'd2;
  localparam logic [1:0] ST_FLUSH2 = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic        flush_q, flush_d;
  logic [15:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        redirect;

  assign pc_plus4      = pc_q + 32'd4;
  // Word offset shifted into bytes; the top two offset bits fall off the end.
  assign branch_target = branch_pc_i + (branch_offset_i << 2);
  assign jump_target   = {pc_plus4[31:28], jump_addr_i, 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    flush_d    = 1'b0;
    redirect   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d    = ST_RUN;
        pc_valid_d = 1'b1;
      end
      ST_RUN: begin
        if (branch_i) begin
          pc_d     = branch_target;
          state_d  = ST_FLUSH1;
          flush_d  = 1'b1;
          redirect = 1'b1;
        end else if (jump_i) begin
          pc_d     = jump_target;
          state_d  = ST_FLUSH2;
          flush_d  = 1'b1;
          redirect = 1'b1;
        end else if (!stall_i) begin
          pc_d = pc_plus4;
        end
      end
      ST_FLUSH1: begin
        pc_d    = pc_plus4;
        state_d = ST_FLUSH2;
        flush_d = 1'b1;
      end
      default: begin
        pc_d    = pc_plus4;
        state_d = ST_RUN;
      end
    endcase
    cnt_d = (redirect && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      cnt_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_o           = pc_q;
  assign pc_valid_o     = pc_valid_q;
  assign flush_o        = flush_q;
  assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer; expected outputs are queued as each step is driven
// and retired one edge later.
module tb_branch_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_pc_i;
  logic [31:0] branch_offset_i;
  logic        jump_i;
  logic [25:0] jump_addr_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        flush_o;
  logic [15:0] redirect_cnt_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        vld;
    logic        fl;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  branch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .branch_i       (branch_i),
    .branch_pc_i    (branch_pc_i),
    .branch_offset_i(branch_offset_i),
    .jump_i         (jump_i),
    .jump_addr_i    (jump_addr_i),
    .pc_o           (pc_o),
    .pc_valid_o     (pc_valid_o),
    .flush_o        (flush_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_now(input string tag, input logic [31:0] pc, input logic vld,
                         input logic fl, input logic [15:0] cnt);
    chk({tag, ".pc"}, pc_o, pc);
    chk({tag, ".vld"}, {31'd0, pc_valid_o}, {31'd0, vld});
    chk({tag, ".flush"}, {31'd0, flush_o}, {31'd0, fl});
    chk({tag, ".cnt"}, {16'd0, redirect_cnt_o}, {16'd0, cnt});
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then retire them.
  task automatic step(input string tag, input logic br, input logic [31:0] bpc,
                      input logic [31:0] boff, input logic jmp, input logic [25:0] jaddr,
                      input logic stl, input logic [31:0] epc, input logic evld,
                      input logic efl, input logic [15:0] ecnt);
    exp_t e;
    branch_i        = br;
    branch_pc_i     = bpc;
    branch_offset_i = boff;
    jump_i          = jmp;
    jump_addr_i     = jaddr;
    stall_i         = stl;
    exp_q.push_back('{pc: epc, vld: evld, fl: efl, cnt: ecnt});
    @(posedge clk_i);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_now(tag, e.pc, e.vld, e.fl, e.cnt);
    end
  endtask

  task automatic idle(input string tag, input logic [31:0] epc, input logic efl,
                      input logic [15:0] ecnt);
    step(tag, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, 1'b0, epc, 1'b1, efl, ecnt);
  endtask

  initial begin
    rst_i = 1'b0;
    stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0;
    branch_pc_i = 32'h0; branch_offset_i = 32'h0; jump_addr_i = 26'h0;

    #12;
    chk_now("reset", 32'h0, 1'b0, 1'b0, 16'd0);
    #5 rst_i = 1'b1;
    #1;
    chk_now("boot", 32'h0, 1'b0, 1'b0, 16'd0);

    // Requests during BOOT must be ignored.
    step("boot_ignore", 1'b1, 32'h100, 32'h4, 1'b1, 26'h55, 1'b1, 32'h0, 1'b1, 1'b0, 16'd0);
    idle("seq4", 32'h4, 1'b0, 16'd0);
    idle("seq8", 32'h8, 1'b0, 16'd0);
    idle("seq12", 32'hC, 1'b0, 16'd0);

    step("br_tgt", 1'b1, 32'h100, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0, 32'h0F8, 1'b1, 1'b1, 16'd1);
    idle("br_f2", 32'h0FC, 1'b1, 16'd1);
    idle("br_run", 32'h100, 1'b0, 16'd1);
    idle("br_seq", 32'h104, 1'b0, 16'd1);

    // Branch + jump + stall together: branch wins, single count.
    step("bjs", 1'b1, 32'h4000_0000, 32'h2, 1'b1, 26'h3FF_FFFF, 1'b1,
         32'h4000_0008, 1'b1, 1'b1, 16'd2);
    step("f1_ignore", 1'b1, 32'h200, 32'h0, 1'b1, 26'h1, 1'b1,
         32'h4000_000C, 1'b1, 1'b1, 16'd2);
    idle("bjs_run", 32'h4000_0010, 1'b0, 16'd2);

    step("jmp_tgt", 1'b0, 32'h0, 32'h0, 1'b1, 26'h000_0040, 1'b0,
         32'h4000_0100, 1'b1, 1'b1, 16'd3);
    idle("jmp_run", 32'h4000_0104, 1'b0, 16'd3);
    idle("jmp_seq", 32'h4000_0108, 1'b0, 16'd3);

    step("wrap_br", 1'b1, 32'hFFFF_FFF0, 32'h1, 1'b0, 26'h0, 1'b0,
         32'hFFFF_FFF4, 1'b1, 1'b1, 16'd4);
    idle("wrap_f2", 32'hFFFF_FFF8, 1'b1, 16'd4);
    idle("wrap_top", 32'hFFFF_FFFC, 1'b0, 16'd4);
    idle("wrap_zero", 32'h0, 1'b0, 16'd4);
    for (int i = 0; i < 3; i++)
      step("stall", 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0, 1'b1, 1'b0, 16'd4);
    idle("unstall", 32'h4, 1'b0, 16'd4);

    // Offset bits [31:30] are shifted out of the target.
    step("off_hi", 1'b1, 32'h10, 32'hC000_0001, 1'b0, 26'h0, 1'b0, 32'h14, 1'b1, 1'b1, 16'd5);
    idle("off_f2", 32'h18, 1'b1, 16'd5);
    idle("off_run", 32'h1C, 1'b0, 16'd5);

    step("pre_rst", 1'b1, 32'h20, 32'h0, 1'b0, 26'h0, 1'b0, 32'h20, 1'b1, 1'b1, 16'd6);
    #2 rst_i = 1'b0;
    #1;
    chk_now("async_rst", 32'h0, 1'b0, 1'b0, 16'd0);
    @(posedge clk_i);
    #1;
    chk_now("rst_hold", 32'h0, 1'b0, 1'b0, 16'd0);
    rst_i = 1'b1;
    #1;
    chk_now("reboot", 32'h0, 1'b0, 1'b0, 16'd0);
    idle("reboot_run", 32'h0, 1'b0, 16'd0);
    idle("reboot_seq", 32'h4, 1'b0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Clock and reset: the block SHALL have one clock, `clk_i`, with all state on its rising edge.
REQ-002 Reset: `rst_i` SHALL be asynchronous and active-low.
REQ-003 Parameter `RESET_PC`, default 32'h0000_0000: the PC value loaded by reset.
REQ-004 Ports SHALL be exactly as follows (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- stall_i  in  1  hazard stall; hold PC
- branch_i  in  1  taken branch resolved this cycle
- branch_pc_i  in  32  PC+4 of the resolving branch
- branch_offset_i  in  32  sign-extended immediate, word units
- jump_i  in  1  jump decoded this cycle
- jump_addr_i  in  26  jump target field
- pc_o  out  32  fetch address
- pc_valid_o  out  1  pc_o is a valid fetch
- flush_o  out  1  kill the instruction in IF/ID
- redirect_cnt_o  out  16  count of taken redirects

Function
REQ-005 States: BOOT, RUN, FLUSH1 and FLUSH2, held in a registered state variable.
REQ-006 BOOT SHALL last exactly one cycle after reset release, then go to RUN.
- pc_o SHALL hold RESET_PC in BOOT.
- pc_valid_o=0 in BOOT.
REQ-007 In RUN, the next-PC priority SHALL be branch_i > jump_i > stall_i > sequential.
REQ-008 Branch target SHALL be branch_pc_i + (branch_offset_i << 2), computed modulo 2^32.
- Bits [31:30] of the offset are discarded by the shift.
REQ-009 Jump target SHALL be {pc_plus4[31:28], jump_addr_i, 2'b00}, where pc_plus4 = pc_o + 4.
REQ-010 Sequential next PC SHALL be pc_o + 4, wrapping: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-011 Stall in RUN with no branch or jump: pc_o SHALL hold and pc_valid_o SHALL stay 1.
REQ-012 Taken branch in RUN:
- pc_o loads the branch target next edge.
- State goes to FLUSH1, then FLUSH2, then RUN.
- flush_o=1 in both FLUSH cycles.
REQ-013 Jump in RUN with no branch:
- pc_o loads the jump target next edge.
- State goes to FLUSH2, then RUN.
- flush_o=1 for that one cycle.
REQ-014 In FLUSH1 and FLUSH2, branch_i, jump_i and stall_i SHALL be ignored.
- pc_o SHALL advance by +4 each cycle.
- pc_valid_o=1.
REQ-015 Branch and jump asserted together: the branch SHALL win and the jump SHALL be dropped.
REQ-016 flush_o SHALL be a registered, state-decoded output: high exactly in FLUSH1 and FLUSH2.
REQ-017 redirect_cnt_o SHALL increment by 1 on each accepted branch or jump.
- It saturates at 16'hFFFF.
- It does not count ignored requests.
REQ-018 All outputs SHALL be registered or decoded from registered state only; no combinational input-to-output paths.

Reset
REQ-019 When rst_i is low, the block SHALL asynchronously set:
- state=BOOT
- pc_o=RESET_PC
- pc_valid_o=0
- flush_o=0
- redirect_cnt_o=0
REQ-020 Reset asserted mid-FLUSH SHALL abort the flush; no residual flush_o after release.
REQ-021 Inputs SHALL be ignored during reset and during BOOT.

Verification
REQ-022 Reset then free-run: release reset with RESET_PC=0 and no requests -> pc_o = 0 (BOOT), then 0, 4, 8, 12 with pc_valid_o=1 from the RUN cycle on.
REQ-023 Taken branch: branch_pc_i=32'h100, branch_offset_i=32'hFFFF_FFFE -> next pc_o=32'h0F8; flush_o high 2 cycles; pc_o 0x0F8, 0x0FC, 0x100; redirect_cnt_o=1.
REQ-024 Jump: pc_o=32'h4000_0010, jump_addr_i=26'h000_0040 -> next pc_o=32'h4000_0100; flush_o high 1 cycle.
REQ-025 Simultaneous branch+jump+stall: branch target taken; jump dropped; redirect_cnt_o +1 only; a branch_i pulse in FLUSH1 is ignored.
REQ-026 Wrap and stall:
- pc_o=32'hFFFF_FFFC, no stall -> pc_o=0.
- stall_i high 3 cycles -> pc_o held 3 cycles.
REQ-027 Reset mid-flush: assert rst_i in FLUSH1 -> flush_o=0 and pc_o=RESET_PC immediately, asynchronously.
